// File: rtl/debug_tx_pkg.sv
// Shared types and constants for the serial debug frame transmitter.
// Holds the serializer state encoding, the frame geometry and the default sync byte.
package debug_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int FRAME_BYTES = 9;
    localparam int DATA_BYTES  = FRAME_BYTES - 2;
    localparam int BYTE_IDX_W  = $clog2(FRAME_BYTES);

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Modulo-256 accumulate used by the frame checksum.
    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer with a load/done handshake.
// A load presented while idle, or in the last cycle of a stop bit, starts the next byte seamlessly.
module uart_tx_byte
    import debug_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output tx_state_e  state_o,
    output logic       tx_o
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state_reg,   state_next;
    logic [TW-1:0] timer_reg,   timer_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg,   shift_next;
    logic          tx_reg,      tx_next;
    logic          bit_end;

    assign bit_end = (timer_reg == TIMER_MAX);
    assign state_o = state_reg;
    assign tx_o    = tx_reg;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        done_o       = 1'b0;
        tx_next      = 1'b1;

        if (state_reg != IDLE) begin
            timer_next = bit_end ? '0 : timer_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (load_i) begin
                    state_next = START;
                    shift_next = data_i;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next   = STOP;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_o = 1'b1;
                    if (load_i) begin
                        state_next = START;
                        shift_next = data_i;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // The line register follows the next state so a bit appears the cycle its state is entered.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: rtl/debug_frame_tx.sv
// Captures the seven cpu debug bytes on a snapshot and ships them as a 9-byte UART frame:
// sync byte, port1..port7, then the modulo-256 sum of the captured bytes.
module debug_frame_tx
    import debug_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       snap_i,
    output logic       snap_ready_o,
    input  logic [7:0] debug_port1_i,
    input  logic [7:0] debug_port2_i,
    input  logic [7:0] debug_port3_i,
    input  logic [7:0] debug_port4_i,
    input  logic [7:0] debug_port5_i,
    input  logic [7:0] debug_port6_i,
    input  logic [7:0] debug_port7_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(FRAME_BYTES - 1);

    tx_state_e               ser_state;
    logic                    ser_done;
    logic                    ser_load;
    logic [7:0]              ser_data;
    logic                    accept;
    logic                    last_byte;
    logic [BYTE_IDX_W-1:0]   byte_idx_reg;
    logic [BYTE_IDX_W-1:0]   load_idx;
    logic [2:0]              data_sel;
    logic                    frame_done_reg;
    logic [7:0]              checksum;
    logic [7:0]              port_bytes  [DATA_BYTES];
    logic [7:0]              capture_reg [DATA_BYTES];

    assign port_bytes[0] = debug_port1_i;
    assign port_bytes[1] = debug_port2_i;
    assign port_bytes[2] = debug_port3_i;
    assign port_bytes[3] = debug_port4_i;
    assign port_bytes[4] = debug_port5_i;
    assign port_bytes[5] = debug_port6_i;
    assign port_bytes[6] = debug_port7_i;

    assign snap_ready_o = (ser_state == IDLE);
    assign busy_o       = !snap_ready_o;
    assign accept       = snap_i && snap_ready_o;
    assign last_byte    = (byte_idx_reg == LAST_IDX);
    assign frame_done_o = frame_done_reg;

    // The sync byte is loaded on the accepting edge; later bytes are loaded as each stop bit ends.
    assign ser_load = accept || (ser_done && !last_byte);
    assign load_idx = accept ? '0 : byte_idx_reg + 1'b1;
    assign data_sel = 3'(load_idx - 1'b1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                capture_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                capture_reg[i] <= port_bytes[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            byte_idx_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= ser_done && last_byte;
            if (accept) begin
                byte_idx_reg <= '0;
            end else if (ser_done) begin
                byte_idx_reg <= last_byte ? '0 : byte_idx_reg + 1'b1;
            end
        end
    end

    always_comb begin
        checksum = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            checksum = add8(checksum, capture_reg[i]);
        end
    end

    always_comb begin
        ser_data = SYNC_BYTE;
        if (load_idx == LAST_IDX) begin
            ser_data = checksum;
        end else if (load_idx != '0) begin
            ser_data = capture_reg[data_sel];
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (ser_load),
        .data_i  (ser_data),
        .done_o  (ser_done),
        .state_o (ser_state),
        .tx_o    (tx_o)
    );

endmodule

// File: tb/tb_debug_frame_tx.sv
// Self-checking bench for debug_frame_tx: table-driven frames plus hand-written corner sequences.
// A line monitor decodes tx and compares every byte against a queue filled when frames are requested.
module tb_debug_frame_tx;

    localparam int CPB        = 4;
    localparam int FRAME_CYC  = 9 * 10 * CPB;
    localparam int WAIT_LIMIT = 2000;

    typedef logic [7:0] bytes7_t [7];
    typedef struct {
        bytes7_t    ports;
        logic [7:0] csum;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       snap_i;
    logic [7:0] port_v [7];
    logic       snap_ready_o;
    logic       tx_o;
    logic       busy_o;
    logic       frame_done_o;

    int         checks = 0;
    int         errors = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q [$];
    vec_t       vecs [4];

    always #5 clk = ~clk;

    debug_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .snap_i       (snap_i),
        .snap_ready_o (snap_ready_o),
        .debug_port1_i(port_v[0]),
        .debug_port2_i(port_v[1]),
        .debug_port3_i(port_v[2]),
        .debug_port4_i(port_v[3]),
        .debug_port5_i(port_v[4]),
        .debug_port6_i(port_v[5]),
        .debug_port7_i(port_v[6]),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always @(negedge clk) begin
        if (busy_o === 1'b1) busy_cnt++;
        if (frame_done_o === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Decodes the line, sampling each bit in its second cycle.
    initial begin : monitor
        logic [7:0] b;
        logic [7:0] e;
        logic       ok;
        logic       start_s;
        logic       stop_s;
        forever begin
            @(negedge clk);
            if (reset_i === 1'b0 && tx_o === 1'b0) begin
                ok = 1'b1;
                @(negedge clk);
                if (reset_i !== 1'b0) ok = 1'b0;
                start_s = tx_o;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    if (reset_i !== 1'b0) ok = 1'b0;
                    b[i] = tx_o;
                end
                repeat (CPB) @(negedge clk);
                if (reset_i !== 1'b0) ok = 1'b0;
                stop_s = tx_o;
                if (ok) begin
                    check("start_bit", 32'(start_s), 32'h0);
                    check("stop_bit", 32'(stop_s), 32'h1);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got %02h, expected no byte", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e) begin
                            errors++;
                            $display("FAIL rx_byte: got %02h, expected %02h", b, e);
                        end else begin
                            $display("ok   rx_byte: %02h", b);
                        end
                    end
                end
                repeat (CPB - 2) @(negedge clk);
            end
        end
    end

    task automatic push_frame(input bytes7_t v, input logic [7:0] csum);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 7; i++) exp_q.push_back(v[i]);
        exp_q.push_back(csum);
    endtask

    task automatic send_frame(input bytes7_t v, input logic [7:0] csum);
        @(negedge clk);
        port_v = v;
        snap_i = 1'b1;
        push_frame(v, csum);
        @(negedge clk);
        snap_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < WAIT_LIMIT; n++) begin
            @(negedge clk);
            if (frame_done_o === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: frame_done timeout, got none, expected pulse within %0d cycles", name, WAIT_LIMIT);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int busy_base;
        int done_base;
        int low_cnt;
        bytes7_t other;

        vecs[0].ports = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}; vecs[0].csum = 8'h1C;
        vecs[1].ports = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[1].csum = 8'hF9;
        vecs[2].ports = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70}; vecs[2].csum = 8'hC0;
        vecs[3].ports = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}; vecs[3].csum = 8'h01;
        other         = '{8'h5A, 8'h33, 8'hC3, 8'h99, 8'h42, 8'h17, 8'hE8};

        reset_i = 1'b1;
        snap_i  = 1'b0;
        port_v  = '{default: 8'h00};
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_o), 32'h1);
        check("reset_busy", 32'(busy_o), 32'h0);
        check("reset_ready", 32'(snap_ready_o), 32'h1);
        check("reset_done", 32'(frame_done_o), 32'h0);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven frames
        foreach (vecs[k]) begin
            busy_base = busy_cnt;
            done_base = done_cnt;
            send_frame(vecs[k].ports, vecs[k].csum);
            wait_done("frame_done");
            repeat (3) @(negedge clk);
            check("busy_cycles", 32'(busy_cnt - busy_base), 32'(FRAME_CYC));
            check("done_pulses", 32'(done_cnt - done_base), 32'h1);
            check("queue_drained", 32'(exp_q.size()), 32'h0);
            check("idle_ready", 32'(snap_ready_o), 32'h1);
            check("idle_tx", 32'(tx_o), 32'h1);
        end

        // Back-to-back: snap held high across two frames
        done_base = done_cnt;
        @(negedge clk);
        port_v = vecs[2].ports;
        snap_i = 1'b1;
        push_frame(vecs[2].ports, vecs[2].csum);
        push_frame(vecs[2].ports, vecs[2].csum);
        wait_done("b2b_first_done");
        check("b2b_done_tx_idle", 32'(tx_o), 32'h1);
        check("b2b_done_ready", 32'(snap_ready_o), 32'h1);
        check("b2b_done_busy", 32'(busy_o), 32'h0);
        @(negedge clk);
        snap_i = 1'b0;
        check("b2b_next_start", 32'(tx_o), 32'h0);
        wait_done("b2b_second_done");
        repeat (3) @(negedge clk);
        check("b2b_done_pulses", 32'(done_cnt - done_base), 32'h2);
        check("b2b_queue_drained", 32'(exp_q.size()), 32'h0);

        // Request while busy is dropped
        done_base = done_cnt;
        send_frame(vecs[0].ports, vecs[0].csum);
        repeat (100) @(negedge clk);
        check("busy_ready_low", 32'(snap_ready_o), 32'h0);
        port_v = other;
        snap_i = 1'b1;
        @(negedge clk);
        snap_i = 1'b0;
        wait_done("busy_req_done");
        low_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) low_cnt++;
        end
        check("busy_req_line_idle", 32'(low_cnt), 32'h0);
        check("busy_req_ready", 32'(snap_ready_o), 32'h1);
        check("busy_req_pulses", 32'(done_cnt - done_base), 32'h1);
        check("busy_req_queue", 32'(exp_q.size()), 32'h0);

        // Capture isolation: ports zeroed one cycle after accept
        send_frame(vecs[3].ports, vecs[3].csum);
        port_v = '{default: 8'h00};
        wait_done("iso_done");
        repeat (3) @(negedge clk);
        check("iso_queue", 32'(exp_q.size()), 32'h0);

        // Reset during the start bit of byte 4
        send_frame(vecs[1].ports, vecs[1].csum);
        repeat (4 * 10 * CPB) @(negedge clk);
        check("pre_reset_tx", 32'(tx_o), 32'h0);
        reset_i = 1'b1;
        #1;
        check("async_reset_tx", 32'(tx_o), 32'h1);
        check("async_reset_busy", 32'(busy_o), 32'h0);
        repeat (5) @(negedge clk);
        reset_i = 1'b0;
        exp_q.delete();
        repeat (50) @(negedge clk);
        check("post_reset_tx", 32'(tx_o), 32'h1);
        check("post_reset_ready", 32'(snap_ready_o), 32'h1);
        busy_base = busy_cnt;
        send_frame(vecs[0].ports, vecs[0].csum);
        wait_done("post_reset_done");
        repeat (3) @(negedge clk);
        check("post_reset_busy_cycles", 32'(busy_cnt - busy_base), 32'(FRAME_CYC));
        check("post_reset_queue", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_frame_tx.md
# debug_frame_tx

Serial debug transmitter that consumes the seven 8-bit debug ports produced by the cpu top level and ships them to the host-side serial debugger. On a snapshot request it latches all seven bytes in one cycle, then transmits a 9-byte frame over a UART 8N1 line: sync byte, seven data bytes, checksum. It sits directly downstream of `cpu`, between its `debug_port1..7` outputs and the board's UART TX pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Legal range is ≥ 2.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

Ports:
- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `snap_i`  in  1  snapshot request (valid).
- `snap_ready_o`  out  1  block can accept a snapshot.
- `debug_port1_i` .. `debug_port7_i`  in  8 each  bytes to capture; port1 is sent first.
- `tx_o`  out  1  UART line; idles high.
- `busy_o`  out  1  a frame is in flight.
- `frame_done_o`  out  1  one-cycle pulse when a frame completes.

## Operation
- Handshake: a snapshot is accepted on the rising edge where `snap_i && snap_ready_o`. On that edge all seven inputs are registered. Inputs are ignored at all other times.
- `snap_ready_o` = 1 only in IDLE. `snap_i` asserted while busy has no effect and is not queued.
- Frame order: `SYNC_BYTE`, port1 … port7, checksum.
- Checksum = (port1 + … + port7) mod 256, taken over the captured values. The sync byte is excluded.
- Byte format: start bit (0), data bits LSB first, stop bit (1).
- FSM states:
  - IDLE → START on accept.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if the byte index < 8, with the index incremented.
  - STOP → IDLE after byte index 8.
- Counters:
  - Bit-timer: width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT`-1, then wraps.
  - Bit index: 0..7.
  - Byte index: 0..8.
- `busy_o` = 1 in every state except IDLE.
- `frame_done_o` is a registered pulse. It is high for exactly the one cycle after the STOP→IDLE transition.
- Reset values:
  - `tx_o` = 1, `busy_o` = 0, `snap_ready_o` = 1, `frame_done_o` = 0.
  - FSM = IDLE; all counters = 0; capture registers = 0.
- Reset mid-frame: the frame is abandoned and `tx_o` goes high immediately (asynchronously). After release the block is in IDLE. No partial frame resumes.

## Timing
- `tx_o` is driven from a register.
- The start bit of the sync byte appears on `tx_o` in the cycle after the accepting edge. That is 1 cycle of latency.
- Each bit is held for exactly `CLKS_PER_BIT` cycles.
- A full frame is 9 × 10 × `CLKS_PER_BIT` cycles, measured from the first start-bit cycle to the end of the final stop bit.
- Back-to-back frames:
  - In the `frame_done_o` cycle the block is in IDLE and `snap_ready_o` = 1.
  - A request accepted in that cycle starts its start bit in the following cycle.
  - The minimum gap between frames is therefore 1 cycle of idle-high line.
- Changes on `debug_port*_i` during a frame never alter the bytes being sent.

## Structure
- Package `debug_tx_pkg` holds:
  - the state enum (IDLE/START/DATA/STOP);
  - `FRAME_BYTES` = 9;
  - the default `SYNC_BYTE`.
- Sub-module `uart_tx_byte` is the byte serializer. It contains the bit timer, the bit index and the START/DATA/STOP handling, and has a load/done handshake.
- `debug_frame_tx` contains:
  - the capture registers;
  - the checksum adder;
  - the byte-index sequencer;
  - the selection of the outgoing byte (sync / data / checksum).

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- Basic frame: ports = 01,02,03,04,05,06,07, pulse `snap_i` → line decodes A5 01 02 03 04 05 06 07 1C. `busy_o` is high for 360 cycles. `frame_done_o` pulses once.
- Checksum wrap: all ports = FF → checksum byte = F9. Every data byte is sent LSB first with correct start and stop bits.
- Back-to-back: hold `snap_i` = 1 continuously → the second frame's start bit follows the first frame's `frame_done_o` cycle by exactly 1 cycle. Every frame decodes correctly.
- Request while busy: pulse `snap_i` mid-frame with different port values → no effect. After the frame ends the line stays idle with `snap_ready_o` = 1 and no second frame.
- Capture isolation: change all ports to 00 one cycle after accept → the frame still carries the originally captured bytes and checksum.
- Reset mid-frame: assert `reset_i` during byte 4 → `tx_o` = 1 and `busy_o` = 0 immediately. After release, a new snapshot produces a complete, correct frame.
